// File: rtl/mul_arbiter_if.sv
// mul_arbiter_if
//   Bundles the requester handshake, the response return path and the
//   multiplier control/data lines of one mul_arbiter instance.
//   Parameters: N (operand width), NUM_REQ (number of requesters).
//   Modports:
//     slave  - the arbiter: takes requests and mul results, drives
//              req_ready/rsp_* and the mul control/operand lines
//     master - the environment: requesters plus the multiplier
//   Signals:
//     req_valid[NUM_REQ], req_a/req_b[NUM_REQ*N] (requester i at [i*N +: N])
//     req_ready[NUM_REQ], rsp_valid[NUM_REQ], rsp_data[2N], rsp_err
//     mul_rst, mul_start, mul_a[N], mul_b[N], mul_out[2N], mul_busy
interface mul_arbiter_if #(
   parameter int N       = 16,
   parameter int NUM_REQ = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ*N-1:0] req_a;
   logic [NUM_REQ*N-1:0] req_b;
   logic [NUM_REQ-1:0]   req_ready;
   logic [NUM_REQ-1:0]   rsp_valid;
   logic [2*N-1:0]       rsp_data;
   logic                 rsp_err;
   logic                 mul_rst;
   logic                 mul_start;
   logic [N-1:0]         mul_a;
   logic [N-1:0]         mul_b;
   logic [2*N-1:0]       mul_out;
   logic                 mul_busy;

   modport slave (
      input  req_valid, req_a, req_b, mul_out, mul_busy,
      output req_ready, rsp_valid, rsp_data, rsp_err,
             mul_rst, mul_start, mul_a, mul_b
   );

   modport master (
      output req_valid, req_a, req_b, mul_out, mul_busy,
      input  req_ready, rsp_valid, rsp_data, rsp_err,
             mul_rst, mul_start, mul_a, mul_b
   );
endinterface

// File: rtl/mul_arbiter.sv
// mul_arbiter
//   Shares one shift-add multiplier between NUM_REQ requesters. Requests are
//   granted round-robin; for each grant the arbiter clears the multiplier
//   accumulator, holds start high for two cycles, waits for busy to drop and
//   returns the product to the granted requester with a one-cycle rsp_valid.
//   Ports:
//     clk  - clock, rising edge
//     rst  - asynchronous, active-high reset
//     bus  - mul_arbiter_if.slave (requests, responses, multiplier lines)
//   Optional feature: define MUL_ARB_TIMEOUT_EN to bound the WAIT state.
//   A multiplier still busy after N+4 WAIT cycles is reset and the requester
//   gets rsp_valid with rsp_err=1 and rsp_data=0. Without the macro WAIT
//   waits indefinitely and rsp_err is tied 0.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   IDLE   | no operation; grant next requester round-robin
//   CLEAR  | mul_rst high one cycle to clear the accumulator
//   LAUNCH | mul_start high for two cycles
//   WAIT   | wait for mul_busy low, then capture product and respond
module mul_arbiter #(
   parameter int N       = 16,
   parameter int NUM_REQ = 2
) (
   input  logic          clk,
   input  logic          rst,
   mul_arbiter_if.slave  bus
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_CLEAR,
      S_LAUNCH,
      S_WAIT
   } state_t;

   state_t               state;
   logic [IDX_W-1:0]     ptr;
   logic                 launch_cnt;
   logic [NUM_REQ-1:0]   req_ready_q;
   logic [NUM_REQ-1:0]   rsp_valid_q;
   logic [2*N-1:0]       rsp_data_q;
   logic                 mul_rst_q;
   logic                 mul_start_q;
   logic [N-1:0]         mul_a_q;
   logic [N-1:0]         mul_b_q;

`ifdef MUL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(N + 4) + 1;
   // Loaded on WAIT entry; terminal count reached on the (N+4)th busy cycle.
   localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(N + 3);

   logic [CNT_W-1:0]     wait_cnt;
   logic                 rsp_err_q;
`endif

   // Round-robin scan: first requester after ptr, wrapping around.
   logic                 gnt_found;
   logic [IDX_W-1:0]     gnt_idx;
   logic [IDX_W-1:0]     cand;
   int                   scan;

   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      scan      = 0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         scan = (int'(ptr) + k) % NUM_REQ;
         cand = IDX_W'(scan);
         if (!gnt_found && bus.req_valid[cand]) begin
            gnt_found = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         ptr         <= IDX_W'(NUM_REQ - 1);
         launch_cnt  <= 1'b0;
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         rsp_data_q  <= '0;
         mul_rst_q   <= 1'b0;
         mul_start_q <= 1'b0;
         mul_a_q     <= '0;
         mul_b_q     <= '0;
`ifdef MUL_ARB_TIMEOUT_EN
         wait_cnt    <= '0;
         rsp_err_q   <= 1'b0;
`endif
      end else begin
         // Handshake pulses and the clear strobe are single-cycle by default.
         req_ready_q <= '0;
         rsp_valid_q <= '0;
         mul_rst_q   <= 1'b0;
`ifdef MUL_ARB_TIMEOUT_EN
         rsp_err_q   <= 1'b0;
`endif
         case (state)
            S_IDLE: begin
               mul_start_q <= 1'b0;
               if (gnt_found) begin
                  req_ready_q[gnt_idx] <= 1'b1;
                  mul_a_q              <= bus.req_a[gnt_idx*N +: N];
                  mul_b_q              <= bus.req_b[gnt_idx*N +: N];
                  ptr                  <= gnt_idx;
                  mul_rst_q            <= 1'b1;
                  state                <= S_CLEAR;
               end
            end

            S_CLEAR: begin
               mul_start_q <= 1'b1;
               launch_cnt  <= 1'b1;
               state       <= S_LAUNCH;
            end

            // Two start cycles so the multiplier's edge detector always
            // samples a rising edge.
            S_LAUNCH: begin
               if (launch_cnt == 1'b0) begin
                  mul_start_q <= 1'b0;
                  state       <= S_WAIT;
`ifdef MUL_ARB_TIMEOUT_EN
                  wait_cnt    <= WAIT_LOAD;
`endif
               end else begin
                  launch_cnt <= launch_cnt - 1'b1;
               end
            end

            S_WAIT: begin
               if (!bus.mul_busy) begin
                  rsp_data_q       <= bus.mul_out;
                  rsp_valid_q[ptr] <= 1'b1;
                  state            <= S_IDLE;
               end
`ifdef MUL_ARB_TIMEOUT_EN
               else if (wait_cnt == '0) begin
                  mul_rst_q        <= 1'b1;
                  rsp_data_q       <= '0;
                  rsp_valid_q[ptr] <= 1'b1;
                  rsp_err_q        <= 1'b1;
                  state            <= S_IDLE;
               end else begin
                  wait_cnt <= wait_cnt - 1'b1;
               end
`endif
            end

            default: begin
               mul_start_q <= 1'b0;
               state       <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req_ready = req_ready_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_data  = rsp_data_q;
   assign bus.mul_rst   = mul_rst_q;
   assign bus.mul_start = mul_start_q;
   assign bus.mul_a     = mul_a_q;
   assign bus.mul_b     = mul_b_q;
`ifdef MUL_ARB_TIMEOUT_EN
   assign bus.rsp_err   = rsp_err_q;
`else
   assign bus.rsp_err   = 1'b0;
`endif

endmodule
